mult_seq_ctrl: RTL

- FSM controller for the repeated-addition multiplier datapath: operand register A, down-counting register B, accumulator P (16-bit load-enabled registers) and adder.
- Accepts a start request, issues load/clear/add/decrement enables in order, watches the datapath's B==0 flag, and reports busy/done.
- Contains no arithmetic; sits between the requester (testbench or top-level sequencer) and the datapath.

---
 rtl/mult_seq_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mult_seq_ctrl.sv
// Sequencing controller for the repeated-addition multiplier datapath (A, down-counting B, accumulator P).
// Optional watchdog abort: define MULT_SEQ_CTRL_WDOG_EN.
module mult_seq_ctrl #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned MAX_ITER = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic eqz,
  output logic ld_a,
  output logic ld_b,
  output logic clr_p,
  output logic ld_p,
  output logic dec_b,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LD_A  = 3'd1,
    S_LD_B  = 3'd2,
    S_CHECK = 3'd3,
    S_ADD   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] iter_cnt;

  logic ld_a_d;
  logic ld_b_d;
  logic clr_p_d;
  logic ld_p_d;
  logic dec_b_d;
  logic busy_d;
  logic done_d;

`ifdef MULT_SEQ_CTRL_WDOG_EN
  localparam logic [WIDTH-1:0] ITER_LIMIT = WIDTH'(MAX_ITER);
  logic wdog_hit;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
`ifdef MULT_SEQ_CTRL_WDOG_EN
    wdog_hit   = 1'b0;
`endif
    case (state)
      S_IDLE:  if (start) next_state = S_LD_A;
      S_LD_A:  next_state = S_LD_B;
      S_LD_B:  next_state = S_CHECK;
      S_CHECK: begin
        if (eqz) begin
          next_state = S_DONE;
`ifdef MULT_SEQ_CTRL_WDOG_EN
        end else if (iter_cnt == ITER_LIMIT) begin
          next_state = S_DONE;
          wdog_hit   = 1'b1;
`endif
        end else begin
          next_state = S_ADD;
        end
      end
      S_ADD:   next_state = S_CHECK;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Moore decode of the upcoming state, registered below so outputs track the state register
  always_comb begin
    ld_a_d  = 1'b0;
    ld_b_d  = 1'b0;
    clr_p_d = 1'b0;
    ld_p_d  = 1'b0;
    dec_b_d = 1'b0;
    done_d  = 1'b0;
    busy_d  = (next_state != S_IDLE);
    case (next_state)
      S_LD_A: ld_a_d = 1'b1;
      S_LD_B: begin
        ld_b_d  = 1'b1;
        clr_p_d = 1'b1;
      end
      S_ADD: begin
        ld_p_d  = 1'b1;
        dec_b_d = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_a  <= 1'b0;
      ld_b  <= 1'b0;
      clr_p <= 1'b0;
      ld_p  <= 1'b0;
      dec_b <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      ld_a  <= ld_a_d;
      ld_b  <= ld_b_d;
      clr_p <= clr_p_d;
      ld_p  <= ld_p_d;
      dec_b <= dec_b_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  // Iteration counter: bounded by B, so it cannot wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_cnt <= '0;
    end else if (state == S_LD_B) begin
      iter_cnt <= '0;
    end else if (state == S_ADD) begin
      iter_cnt <= iter_cnt + WIDTH'(1);
    end
  end

`ifdef MULT_SEQ_CTRL_WDOG_EN
  // Sticky abort flag, cleared when the next start is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (state == S_IDLE && start) begin
      err <= 1'b0;
    end else if (wdog_hit) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
